// File: rtl/pkg_cpu_if.sv
// rtl/pkg_cpu_if.sv - shared FSM state and response error codes for the CPU-interface demux
// Contents: state_t (demux FSM states), ERR_* response error codes.
package pkg_cpu_if;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Any code other than ERR_NONE is reported upstream as err=1.
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SLAVE   = 2'd1;
  localparam logic [1:0] ERR_DECODE  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/cpuif_watchdog.sv
// rtl/cpuif_watchdog.sv - cycle watchdog for an outstanding downstream transaction
// Ports: clk, reset (sync, active-high), active (transaction in flight),
//        expired (high from the TIMEOUT_CYC-th active cycle on).
module cpuif_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of active cycles already completed, so the
  // current cycle is number cnt+1; saturate so expiry stays asserted.
  always_ff @(posedge clk) begin
    if (reset || !active) begin
      cnt <= '0;
    end else if (cnt < LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = active && (cnt >= LAST);

endmodule

// File: rtl/cpuif_demux.sv
// rtl/cpuif_demux.sv - one-outstanding CPU-interface demux onto N_SLAVES regmap windows
// Build option: CPUIF_DEMUX_TIMEOUT_EN adds the cpuif_watchdog transaction timeout.
// Ports: clk, reset (sync, active-high);
//        s_cpuif_* upstream request/stall/ack channel;
//        m_cpuif_* downstream: per-slave req/stall/ack/err/rd_data, shared is_wr/addr/wr_data/wr_biten.
module cpuif_demux
  import pkg_cpu_if::*;
#(
  parameter int N_SLAVES    = 4,
  parameter int ADDR_W      = 16,
  parameter int SLAVE_AW    = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_cpuif_req,
  input  logic                s_cpuif_req_is_wr,
  input  logic [ADDR_W-1:0]   s_cpuif_addr,
  input  logic [DATA_W-1:0]   s_cpuif_wr_data,
  input  logic [DATA_W-1:0]   s_cpuif_wr_biten,
  output logic                s_cpuif_req_stall_wr,
  output logic                s_cpuif_req_stall_rd,
  output logic                s_cpuif_rd_ack,
  output logic                s_cpuif_rd_err,
  output logic [DATA_W-1:0]   s_cpuif_rd_data,
  output logic                s_cpuif_wr_ack,
  output logic                s_cpuif_wr_err,
  output logic [N_SLAVES-1:0] m_cpuif_req,
  output logic                m_cpuif_req_is_wr,
  output logic [SLAVE_AW-1:0] m_cpuif_addr,
  output logic [DATA_W-1:0]   m_cpuif_wr_data,
  output logic [DATA_W-1:0]   m_cpuif_wr_biten,
  input  logic [N_SLAVES-1:0] m_cpuif_req_stall_wr,
  input  logic [N_SLAVES-1:0] m_cpuif_req_stall_rd,
  input  logic [N_SLAVES-1:0] m_cpuif_rd_ack,
  input  logic [N_SLAVES-1:0] m_cpuif_rd_err,
  input  logic [DATA_W-1:0]   m_cpuif_rd_data [N_SLAVES],
  input  logic [N_SLAVES-1:0] m_cpuif_wr_ack,
  input  logic [N_SLAVES-1:0] m_cpuif_wr_err
);

  localparam int IDX_W = ADDR_W - SLAVE_AW;

  state_t              state;
  logic                is_wr_q;
  logic [SLAVE_AW-1:0] addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   biten_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [N_SLAVES-1:0] sel_q;   // selected slave index, held one-hot
  logic [1:0]          err_code_q;

  logic [IDX_W-1:0]    dec_idx;
  logic                dec_miss;
  logic [N_SLAVES-1:0] dec_sel;
  logic                sel_stall;
  logic                sel_ack;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic                timeout;
  logic                in_resp;

  assign dec_idx  = s_cpuif_addr[ADDR_W-1:SLAVE_AW];
  assign dec_miss = 32'(dec_idx) >= N_SLAVES;

  always_comb begin
    dec_sel = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (32'(dec_idx) == i) dec_sel[i] = 1'b1;
    end
  end

  // Only the selected slave's handshake of the transaction's own type is
  // visible to the FSM; everything else on the downstream side is ignored.
  assign sel_stall = |(sel_q & (is_wr_q ? m_cpuif_req_stall_wr : m_cpuif_req_stall_rd));
  assign sel_ack   = |(sel_q & (is_wr_q ? m_cpuif_wr_ack : m_cpuif_rd_ack));
  assign sel_err   = |(sel_q & (is_wr_q ? m_cpuif_wr_err : m_cpuif_rd_err));

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | m_cpuif_rd_data[i];
    end
  end

`ifdef CPUIF_DEMUX_TIMEOUT_EN
  logic wd_active;
  assign wd_active = (state == ST_ISSUE) || (state == ST_WAIT);

  cpuif_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .active  (wd_active),
    .expired (timeout)
  );
`else
  // No watchdog: a transaction waits for its slave indefinitely.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      biten_q    <= '0;
      rdata_q    <= '0;
      sel_q      <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_cpuif_req) begin
            is_wr_q <= s_cpuif_req_is_wr;
            addr_q  <= s_cpuif_addr[SLAVE_AW-1:0];
            wdata_q <= s_cpuif_wr_data;
            biten_q <= s_cpuif_wr_biten;
            rdata_q <= '0;
            if (dec_miss) begin
              sel_q      <= '0;
              err_code_q <= ERR_DECODE;
              state      <= ST_RESP;
            end else begin
              sel_q      <= dec_sel;
              err_code_q <= ERR_NONE;
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // A slave that takes the request on the expiry cycle still gets
          // its chance to ack; the watchdog fires again in WAIT otherwise.
          if (!sel_stall) begin
            state <= ST_WAIT;
          end else if (timeout) begin
            err_code_q <= ERR_TIMEOUT;
            state      <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (sel_ack) begin
            err_code_q <= sel_err ? ERR_SLAVE : ERR_NONE;
            rdata_q    <= is_wr_q ? '0 : sel_rdata;
            state      <= ST_RESP;
          end else if (timeout) begin
            err_code_q <= ERR_TIMEOUT;
            rdata_q    <= '0;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_cpuif_req       = (state == ST_ISSUE) ? sel_q : '0;
  assign m_cpuif_req_is_wr = is_wr_q;
  assign m_cpuif_addr      = addr_q;
  assign m_cpuif_wr_data   = wdata_q;
  assign m_cpuif_wr_biten  = biten_q;

  assign in_resp              = (state == ST_RESP);
  assign s_cpuif_req_stall_wr = (state != ST_IDLE);
  assign s_cpuif_req_stall_rd = (state != ST_IDLE);
  assign s_cpuif_wr_ack       = in_resp && is_wr_q;
  assign s_cpuif_wr_err       = s_cpuif_wr_ack && (err_code_q != ERR_NONE);
  assign s_cpuif_rd_ack       = in_resp && !is_wr_q;
  assign s_cpuif_rd_err       = s_cpuif_rd_ack && (err_code_q != ERR_NONE);
  assign s_cpuif_rd_data      = s_cpuif_rd_ack ? rdata_q : '0;

endmodule

// File: tb/tb_cpuif_demux.sv
// tb/tb_cpuif_demux.sv - directed table-driven bench for cpuif_demux
module tb_cpuif_demux;

  localparam int NS  = 4;
  localparam int AW  = 16;
  localparam int SAW = 12;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_req, s_is_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_biten;
  logic          s_stall_wr, s_stall_rd, s_rd_ack, s_rd_err, s_wr_ack, s_wr_err;
  logic [DW-1:0] s_rd_data;
  logic [NS-1:0] m_req;
  logic          m_is_wr;
  logic [SAW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_biten;
  logic [NS-1:0] m_stall_wr, m_stall_rd, m_rd_ack, m_rd_err, m_wr_ack, m_wr_err;
  logic [DW-1:0] m_rd_data [NS];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpuif_demux #(
    .N_SLAVES(NS), .ADDR_W(AW), .SLAVE_AW(SAW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .s_cpuif_req(s_req), .s_cpuif_req_is_wr(s_is_wr), .s_cpuif_addr(s_addr),
    .s_cpuif_wr_data(s_wdata), .s_cpuif_wr_biten(s_biten),
    .s_cpuif_req_stall_wr(s_stall_wr), .s_cpuif_req_stall_rd(s_stall_rd),
    .s_cpuif_rd_ack(s_rd_ack), .s_cpuif_rd_err(s_rd_err), .s_cpuif_rd_data(s_rd_data),
    .s_cpuif_wr_ack(s_wr_ack), .s_cpuif_wr_err(s_wr_err),
    .m_cpuif_req(m_req), .m_cpuif_req_is_wr(m_is_wr), .m_cpuif_addr(m_addr),
    .m_cpuif_wr_data(m_wdata), .m_cpuif_wr_biten(m_biten),
    .m_cpuif_req_stall_wr(m_stall_wr), .m_cpuif_req_stall_rd(m_stall_rd),
    .m_cpuif_rd_ack(m_rd_ack), .m_cpuif_rd_err(m_rd_err), .m_cpuif_rd_data(m_rd_data),
    .m_cpuif_wr_ack(m_wr_ack), .m_cpuif_wr_err(m_wr_err)
  );

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] biten;
    int            tgt;     // -1: decode miss, no slave involved
    int            stall;   // cycles the target holds its matching stall
    int            delay;   // extra WAIT cycles before the target acks
    logic          spur;    // drive foreign / wrong-type acks while waiting
    logic          serr;
    logic [DW-1:0] sdata;
    int            lat;     // expected cycles from acceptance edge to upstream ack
    logic          eerr;
    logic [DW-1:0] erdata;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_slaves();
    m_stall_wr = '0; m_stall_rd = '0;
    m_rd_ack = '0; m_rd_err = '0; m_wr_ack = '0; m_wr_err = '0;
    for (int i = 0; i < NS; i++) m_rd_data[i] = '0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int req_cycles, stall_left, ack_cnt, lat;
    logic [NS-1:0] req_seen;
    logic field_bad, stall_bad, rdz_bad, accepted, acked, got, err_v;
    logic [1:0] ack_kind;
    logic [DW-1:0] data_v;
    req_cycles = 0; stall_left = v.stall; ack_cnt = 0; lat = 0;
    req_seen = '0; field_bad = 0; stall_bad = 0; rdz_bad = 0;
    accepted = 0; acked = 0; got = 0; err_v = 0; ack_kind = 2'b00; data_v = '0;

    @(negedge clk);
    chk($sformatf("v%0d_idle_stall", n), 64'({s_stall_wr, s_stall_rd}), 64'(0));
    s_req = 1'b1; s_is_wr = v.is_wr; s_addr = v.addr; s_wdata = v.wdata; s_biten = v.biten;

    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      if (m_req != '0) begin
        req_cycles++;
        req_seen |= m_req;
        if (m_addr !== v.addr[SAW-1:0] || m_is_wr !== v.is_wr ||
            m_wdata !== v.wdata || m_biten !== v.biten) field_bad = 1;
      end
      if (!(s_stall_wr && s_stall_rd)) stall_bad = 1;
      if (s_wr_ack || s_rd_ack) begin
        got = 1; lat = cyc; ack_kind = {s_wr_ack, s_rd_ack};
        err_v = s_wr_ack ? s_wr_err : s_rd_err;
        data_v = s_rd_data;
      end else if (s_rd_data !== '0 || s_rd_err || s_wr_err) begin
        rdz_bad = 1;
      end
      // Request fields are withdrawn so the DUT must rely on its registers.
      s_req = 1'b0; s_is_wr = 1'b0; s_addr = '0; s_wdata = '0; s_biten = '0;
      idle_slaves();
      if (v.tgt >= 0) begin
        if (!accepted && m_req[v.tgt]) begin
          if (stall_left > 0) begin
            stall_left--;
            if (v.is_wr) m_stall_wr[v.tgt] = 1'b1; else m_stall_rd[v.tgt] = 1'b1;
          end else begin
            accepted = 1; ack_cnt = v.delay;
            if (v.is_wr) m_stall_rd[v.tgt] = 1'b1; else m_stall_wr[v.tgt] = 1'b1;
          end
        end else if (accepted && !acked && !got) begin
          if (ack_cnt == 0) begin
            acked = 1;
            m_rd_data[v.tgt] = v.sdata;
            if (v.is_wr) begin
              m_wr_ack[v.tgt] = 1'b1; m_wr_err[v.tgt] = v.serr;
            end else begin
              m_rd_ack[v.tgt] = 1'b1; m_rd_err[v.tgt] = v.serr;
            end
          end else begin
            ack_cnt--;
            if (v.spur) begin
              m_wr_ack[0] = 1'b1; m_wr_err[0] = 1'b1;
              m_rd_ack[1] = 1'b1; m_rd_err[1] = 1'b1; m_rd_data[1] = 32'hBAD0BAD0;
              if (v.is_wr) m_rd_ack[v.tgt] = 1'b1; else m_wr_ack[v.tgt] = 1'b1;
            end
          end
        end
      end
    end

    chk($sformatf("v%0d_latency", n), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d_ack_kind", n), 64'(ack_kind), 64'(v.is_wr ? 2'b10 : 2'b01));
    chk($sformatf("v%0d_err", n), 64'(err_v), 64'(v.eerr));
    chk($sformatf("v%0d_rd_data", n), 64'(data_v), 64'(v.erdata));
    chk($sformatf("v%0d_req_mask", n), 64'(req_seen), 64'((v.tgt < 0) ? 4'b0 : 4'(1 << v.tgt)));
    chk($sformatf("v%0d_req_cycles", n), 64'(req_cycles), 64'((v.tgt < 0) ? 0 : v.stall + 1));
    chk($sformatf("v%0d_fields", n), 64'(field_bad), 64'(0));
    chk($sformatf("v%0d_stalls", n), 64'(stall_bad), 64'(0));
    chk($sformatf("v%0d_rdz", n), 64'(rdz_bad), 64'(0));
    @(negedge clk);
    chk($sformatf("v%0d_after", n),
        64'({s_wr_ack, s_rd_ack, s_stall_wr, s_stall_rd, m_req}), 64'(0));
  endtask

  task automatic reset_in_wait();
    logic bad;
    bad = 0;
    @(negedge clk);
    s_req = 1'b1; s_is_wr = 1'b0; s_addr = 16'h2000; s_wdata = '0; s_biten = '0;
    @(negedge clk);
    s_req = 1'b0; s_addr = '0;
    chk("rw_req_issue", 64'(m_req), 64'(4'b0100));
    @(negedge clk);
    chk("rw_wait_stall", 64'({s_stall_wr, s_stall_rd, m_req}), 64'(6'b110000));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rw_reset_outs",
        64'({s_stall_wr, s_stall_rd, s_rd_ack, s_rd_err, s_wr_ack, s_wr_err, m_req, s_rd_data}), 64'(0));
    m_rd_ack[2] = 1'b1; m_rd_data[2] = 32'h55AA55AA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_slaves();
      if (s_rd_ack || s_wr_ack || s_stall_rd || s_stall_wr || s_rd_data != '0) bad = 1;
    end
    chk("rw_late_ack_ignored", 64'(bad), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    s_req = 1'b0; s_is_wr = 1'b0; s_addr = '0; s_wdata = '0; s_biten = '0;
    idle_slaves();

    //                 is_wr  addr       wdata          biten          tgt st dl spur  serr  sdata          lat eerr  erdata
    vt.push_back('{1'b1, 16'h1004, 32'hDEADBEEF, 32'hFFFFFFFF,  1, 0, 0, 1'b0, 1'b0, 32'h0,         3, 1'b0, 32'h0});
    vt.push_back('{1'b0, 16'h3010, 32'h0,        32'h0,         3, 2, 0, 1'b0, 1'b0, 32'h12345678,  5, 1'b0, 32'h12345678});
    vt.push_back('{1'b0, 16'h5000, 32'h0,        32'h0,        -1, 0, 0, 1'b0, 1'b0, 32'hFFFFFFFF,  1, 1'b1, 32'h0});
    vt.push_back('{1'b1, 16'hF000, 32'h11112222, 32'h0000FFFF, -1, 0, 0, 1'b0, 1'b0, 32'h0,         1, 1'b1, 32'h0});
    vt.push_back('{1'b0, 16'h2008, 32'h0,        32'h0,         2, 0, 2, 1'b1, 1'b0, 32'hA5A50001,  5, 1'b0, 32'hA5A50001});
    vt.push_back('{1'b0, 16'h0FFC, 32'h0,        32'h0,         0, 0, 0, 1'b0, 1'b1, 32'hCAFEF00D,  3, 1'b1, 32'hCAFEF00D});
    vt.push_back('{1'b1, 16'h3FFF, 32'h01020304, 32'h0000FF00,  3, 1, 0, 1'b0, 1'b1, 32'h77777777,  4, 1'b1, 32'h0});
    vt.push_back('{1'b0, 16'h1000, 32'h0,        32'h0,         1, 0, 1, 1'b0, 1'b0, 32'h00000001,  4, 1'b0, 32'h00000001});
`ifdef CPUIF_DEMUX_TIMEOUT_EN
    vt.push_back('{1'b0, 16'h2000, 32'h0,        32'h0,         2, 0, 50, 1'b0, 1'b0, 32'h0,        9, 1'b1, 32'h0});
    vt.push_back('{1'b0, 16'h2000, 32'h0,        32'h0,         2, 0, 6, 1'b0, 1'b0, 32'h0BADF00D,  9, 1'b0, 32'h0BADF00D});
`endif

    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({s_stall_wr, s_stall_rd, s_rd_ack, s_rd_err, s_wr_ack, s_wr_err, m_req, m_is_wr}), 64'(0));
    chk("rst_data", 64'({s_rd_data, m_wdata}), 64'(0));
    chk("rst_fields", 64'({m_biten, m_addr}), 64'(0));
    reset = 1'b0;

    foreach (vt[i]) run_vec(i, vt[i]);

    reset_in_wait();
    run_vec(100, vt[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpuif_demux.md
CPUIF_DEMUX -- requirements
Module: cpuif_demux

Interface
REQ-001 SHALL have parameter N_SLAVES, default 4; number of downstream regmap ports, legal 1..16.
REQ-002 SHALL have parameter ADDR_W, default 16; upstream byte-address width.
REQ-003 SHALL have parameter SLAVE_AW, default 12; per-slave window address width, SLAVE_AW < ADDR_W.
REQ-004 SHALL have parameter DATA_W, default 32; data and biten width.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 255; watchdog limit in cycles.
REQ-006 SHALL have port clk, input, 1; sole clock.
REQ-007 SHALL have port reset, input, 1; synchronous, active-high reset.
REQ-008 SHALL have upstream inputs s_cpuif_req (1), s_cpuif_req_is_wr (1), s_cpuif_addr (ADDR_W), s_cpuif_wr_data (DATA_W) and s_cpuif_wr_biten (DATA_W).
REQ-009 SHALL have upstream outputs s_cpuif_req_stall_wr (1), s_cpuif_req_stall_rd (1), s_cpuif_rd_ack (1), s_cpuif_rd_err (1), s_cpuif_rd_data (DATA_W), s_cpuif_wr_ack (1) and s_cpuif_wr_err (1).
REQ-010 SHALL have downstream outputs m_cpuif_req [N_SLAVES], m_cpuif_req_is_wr, m_cpuif_addr (SLAVE_AW), m_cpuif_wr_data and m_cpuif_wr_biten, the last four shared by all slaves.
REQ-011 SHALL have downstream inputs m_cpuif_req_stall_wr, m_cpuif_req_stall_rd, m_cpuif_rd_ack, m_cpuif_rd_err, m_cpuif_wr_ack and m_cpuif_wr_err, each [N_SLAVES], plus m_cpuif_rd_data [N_SLAVES][DATA_W].

Function
REQ-012 SHALL decode slave index = s_cpuif_addr[ADDR_W-1:SLAVE_AW]; index >= N_SLAVES is a decode miss.
REQ-013 SHALL implement FSM IDLE, ISSUE, WAIT, RESP with one transaction outstanding at most.
REQ-014 SHALL, in IDLE, accept s_cpuif_req in one cycle, register is_wr, addr[SLAVE_AW-1:0], data, biten and index, then go to ISSUE, or go to RESP with err=1 on a decode miss.
REQ-015 SHALL assert both upstream stalls whenever state != IDLE and deassert them in IDLE.
REQ-016 SHALL, in ISSUE, drive m_cpuif_req[idx]=1 only, hold all fields stable, and go to WAIT in the first cycle the matching stall (wr or rd, per is_wr) is low.
REQ-017 SHALL, in WAIT, capture the matching ack from slave idx only (wr_ack for writes, rd_ack for reads), with its err and rd_data, then go to RESP.
REQ-018 SHALL ignore acks from non-selected slaves and acks of the wrong type.
REQ-019 SHALL, in RESP, pulse exactly one upstream ack for one cycle with the captured err and data, then return to IDLE.
REQ-020 SHALL drive s_cpuif_rd_data as 0 except in a read RESP cycle.
REQ-021 SHALL produce, for a zero-wait slave, an upstream ack 3 cycles after acceptance: accept, ISSUE, WAIT with ack captured, RESP.

Reset
REQ-022 SHALL return to IDLE on reset with all outputs 0 and the registered fields cleared.
REQ-023 SHALL, on reset during ISSUE, WAIT or RESP, discard the transaction with no upstream ack; a late slave ack after reset SHALL be ignored.

Configuration
REQ-024 SHALL, with CPUIF_DEMUX_TIMEOUT_EN defined, count cycles spent in ISSUE and WAIT, and go to RESP with err=1 (rd_data=0) and m_cpuif_req deasserted when the count reaches TIMEOUT_CYC.
REQ-025 SHALL let a slave ack in the same cycle as the timeout take precedence over the timeout.
REQ-026 SHALL, with CPUIF_DEMUX_TIMEOUT_EN undefined, contain no counter and wait indefinitely.

Structure
REQ-027 SHALL place the FSM state enum and the decode-miss/timeout error-code constants in the shared package pkg_cpu_if.
REQ-028 SHALL implement the watchdog as sub-module cpuif_watchdog, instantiated only under CPUIF_DEMUX_TIMEOUT_EN.

Verification
REQ-029 Write 0xDEADBEEF to 0x1004, slave 1 acks next cycle -> m_cpuif_req[1] pulse with addr 0x004; s_cpuif_wr_ack=1, wr_err=0, 3 cycles after acceptance.
REQ-030 Read 0x3010, slave 3 stalls 2 cycles then returns 0x12345678 -> request held stable during stall; s_cpuif_rd_data=0x12345678; upstream stalled throughout.
REQ-031 Read 0x5000 with N_SLAVES=4 -> no m_cpuif_req; rd_ack=1, rd_err=1, rd_data=0, 1 cycle after acceptance.
REQ-032 With TIMEOUT_CYC=8 and a silent slave 2, read 0x2000 -> rd_err=1 after 8 cycles; slave 2 ack in the 8th cycle -> normal ack instead.
REQ-033 Reset in WAIT, then slave ack -> no upstream ack; next request completes normally.
REQ-034 Spurious wr_ack from slave 0 during a read to slave 2 -> ignored; only slave 2 rd_ack is forwarded.
